fp_round_unit: RTL

//  Parametrised IEEE-754 rounding stage for the FP multiply/divide datapath: takes a normalised

---
 rtl/fp_round_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fp_round_unit.sv
// IEEE-754 rounding stage: applies RNE/RTZ/RUP/RDN to a normalised fraction with GRS bits,
// propagates mantissa carry into the exponent and saturates on overflow. 2-stage valid/ready pipe.
module fp_round_unit #(
    parameter int unsigned MAN_W = 23,
    parameter int unsigned EXP_W = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [MAN_W+2:0] in_man,
    input  logic [1:0]       rnd_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [MAN_W-1:0] out_man,
    output logic             inexact,
    output logic             overflow
);

    localparam int unsigned SUM_W = MAN_W + 1;
    localparam logic [EXP_W-1:0] EMAX    = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EMAX_M1 = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [1:0] RNE = 2'b00;
    localparam logic [1:0] RTZ = 2'b01;
    localparam logic [1:0] RUP = 2'b10;
    localparam logic [1:0] RDN = 2'b11;

    logic adv1;
    logic adv2;

    // Stage 1 registers
    logic             s1_valid;
    logic             s1_sign;
    logic [EXP_W-1:0] s1_exp;
    logic [MAN_W-1:0] s1_frac;
    logic             s1_inc;
    logic             s1_ix;
    logic [1:0]       s1_mode;
    logic             s1_special;

    // Stage 1 combinational decode
    logic [MAN_W-1:0] frac_c;
    logic             g_c;
    logic             r_c;
    logic             s_c;
    logic             special_c;
    logic             ix_c;
    logic             inc_c;

    // Stage 2 combinational result
    logic [SUM_W-1:0] sum_c;
    logic [EXP_W-1:0] exp_inc_c;
    logic [EXP_W-1:0] nxt_exp_c;
    logic [MAN_W-1:0] nxt_man_c;
    logic             nxt_ix_c;
    logic             nxt_ovf_c;
    logic             to_inf_c;

    // Stage 2 only moves when its output slot is free; stage 1 when stage 2 takes its beat.
    assign adv2     = en & (~out_valid | out_ready);
    assign adv1     = en & (~s1_valid | adv2);
    assign in_ready = adv1;

    assign frac_c    = in_man[MAN_W+2:3];
    assign g_c       = in_man[2];
    assign r_c       = in_man[1];
    assign s_c       = in_man[0];
    assign special_c = (in_exp == EMAX);

    // Increment decision per rounding mode; Inf/NaN pass through untouched.
    always_comb begin
        ix_c  = g_c | r_c | s_c;
        inc_c = 1'b0;
        case (rnd_mode)
            RNE:     inc_c = g_c & (r_c | s_c | frac_c[0]);
            RTZ:     inc_c = 1'b0;
            RUP:     inc_c = ~in_sign & ix_c;
            RDN:     inc_c = in_sign & ix_c;
            default: inc_c = 1'b0;
        endcase
        if (special_c) begin
            inc_c = 1'b0;
            ix_c  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_exp     <= '0;
            s1_frac    <= '0;
            s1_inc     <= 1'b0;
            s1_ix      <= 1'b0;
            s1_mode    <= 2'b00;
            s1_special <= 1'b0;
        end else if (adv1) begin
            s1_valid   <= in_valid;
            s1_sign    <= in_sign;
            s1_exp     <= in_exp;
            s1_frac    <= frac_c;
            s1_inc     <= inc_c;
            s1_ix      <= ix_c;
            s1_mode    <= rnd_mode;
            s1_special <= special_c;
        end
    end

    assign sum_c     = {1'b0, s1_frac} + SUM_W'(s1_inc);
    assign exp_inc_c = s1_exp + EXP_W'(1);

    // Mantissa carry bumps the exponent; reaching EMAX saturates to Inf or max finite by mode.
    always_comb begin
        nxt_exp_c = s1_exp;
        nxt_man_c = sum_c[MAN_W-1:0];
        nxt_ix_c  = s1_ix;
        nxt_ovf_c = 1'b0;
        to_inf_c  = 1'b0;
        if (s1_special) begin
            nxt_man_c = s1_frac;
            nxt_ix_c  = 1'b0;
        end else if (sum_c[MAN_W]) begin
            nxt_exp_c = exp_inc_c;
            nxt_man_c = '0;
            if (exp_inc_c == EMAX) begin
                nxt_ovf_c = 1'b1;
                case (s1_mode)
                    RNE:     to_inf_c = 1'b1;
                    RTZ:     to_inf_c = 1'b0;
                    RUP:     to_inf_c = ~s1_sign;
                    RDN:     to_inf_c = s1_sign;
                    default: to_inf_c = 1'b1;
                endcase
                if (!to_inf_c) begin
                    nxt_exp_c = EMAX_M1;
                    nxt_man_c = '1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_exp   <= '0;
            out_man   <= '0;
            inexact   <= 1'b0;
            overflow  <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            out_sign  <= s1_sign;
            out_exp   <= nxt_exp_c;
            out_man   <= nxt_man_c;
            inexact   <= nxt_ix_c;
            overflow  <= nxt_ovf_c;
        end
    end

endmodule
